gcd_datapath: RTL and testbench
===============================

Name: gcd_datapath

Overview:
- Operand and arithmetic datapath driven by the GCD sequencing controller. It consumes that controller's xload/yload/xhold/yhold/done strobes and produces the x_eq_y/x_gt_y status it branches on.
- Holds the X and Y operand registers and the subtract/compare logic.
- Captures the final GCD into a result register with a valid flag for downstream consumers.

Parameters:
- WIDTH, 8, operand/result bit width.
- CNT_W, 8, iteration counter width (used only with the optional feature).

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- din  input  WIDTH  operand value, sampled during load strobes
- xload  input  1  controller strobe (encoding below)
- yload  input  1  controller strobe
- xhold  input  1  controller strobe; 0 = load X from din
- yhold  input  1  controller strobe; 0 = load Y from din
- done  input  1  controller completion flag
- x_eq_y  output  1  combinational status: X==Y, forced 1 on zero operand
- x_gt_y  output  1  combinational status: X>Y (unsigned)
- gcd_out  output  WIDTH  registered result
- result_valid  output  1  gcd_out holds a valid result
- zero_op  output  1  registered: last result came from a zero operand

Behaviour:
- Reset (rst=0, async): X=0, Y=0, gcd_out=0, result_valid=0, zero_op=0, done_q=0.
  - X=Y=0 at reset, so x_eq_y=1 and x_gt_y=0 out of reset.
- X register update priority per clock:
  - xhold=0 and xload=0: X<=din.
  - Otherwise, xhold=1, xload=1, yload=0, x_eq_y=0: X<=X-Y.
  - Otherwise hold.
- Y register update priority per clock:
  - yhold=0 and yload=0: Y<=din.
  - Otherwise, yhold=1, yload=1, xload=0, x_eq_y=0: Y<=Y-X.
  - Otherwise hold.
- All strobes 1 (idle/finished phases): X and Y hold.
- Illegal combination xhold=0 with xload=1 (likewise for Y): the register holds.
- Subtract guard: no subtraction when x_eq_y=1. This covers the controller's final compare cycle, in which it still drives yload=1/xload=0; the guard prevents Y collapsing to 0.
- Subtraction is unsigned WIDTH-bit. The guards ensure the minuend ≥ subtrahend, so no wrap occurs.
- Compare (combinational from registers):
  - zero = (X==0)|(Y==0).
  - x_eq_y = (X==Y)|zero.
  - x_gt_y = (X>Y) & ~zero.
- Result capture:
  - done_q registers done.
  - On rising edge of done (done & ~done_q): gcd_out<=X|Y (equals X when X==Y, the nonzero operand when one is 0), result_valid<=1, zero_op<=zero.
- Result clear: result_valid and zero_op clear on the first cycle with xhold=0 (a new load begins). gcd_out retains its old value.
- If a new load and a done rising edge occur in the same cycle, the capture wins.
- Latency: result_valid rises 1 clock after done rises.
- Reset mid-computation: immediate clear to reset values. No partial result is exposed.

Optional Feature:
- Macro: GCD_ITER_COUNT_EN.
- Defined:
  - Adds output port iter_count [CNT_W-1:0], reset 0.
  - Cleared when X is loaded (xhold=0 & xload=0).
  - Increments by 1 on each cycle in which X or Y performs a subtraction.
  - Saturates at all-ones and does not wrap.
  - Frozen while result_valid=1.
- Undefined: no port, no counter logic. All other behaviour is identical.

Test Plan:
- Load X=48, Y=18, run controller loop → x_gt_y toggles per compare; done → gcd_out=6, result_valid=1 one cycle after done; iter_count=4 (feature on).
- Load X=7, Y=7 → x_eq_y=1 at first compare, no subtraction; gcd_out=7, zero_op=0, iter_count=0.
- Load X=0, Y=9 → x_eq_y forced 1, x_gt_y=0; gcd_out=9, zero_op=1. Then load X=9, Y=0 → gcd_out=9, zero_op=1.
- Load X=13, Y=1 → 12 successive X<=X-Y steps; gcd_out=1, iter_count=12. With CNT_W=3 → iter_count saturates at 7.
- Load X=255, Y=255 (WIDTH=8) → gcd_out=255, no wrap. Follow with a new load of X=4 → result_valid drops that cycle and gcd_out stays 255 until the next done.
- Assert rst=0 asynchronously mid-loop (X=30, Y=18) → X, Y, gcd_out, result_valid, zero_op all 0 before the next clock edge; x_eq_y=1.

Source files
------------

// File: rtl/gcd_datapath.sv
// GCD operand/subtract/compare datapath with registered result; result_valid rises one clock after done rises, no backpressure.
// Optional iteration counter port iter_count is enabled by defining GCD_ITER_COUNT_EN.
module gcd_datapath #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             xload,
  input  logic             yload,
  input  logic             xhold,
  input  logic             yhold,
  input  logic             done,
  output logic             x_eq_y,
  output logic             x_gt_y,
  output logic [WIDTH-1:0] gcd_out,
  output logic             result_valid,
  output logic             zero_op
`ifdef GCD_ITER_COUNT_EN
  ,
  output logic [CNT_W-1:0] iter_count
`endif
);

  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic             valid_q, valid_d;
  logic             zop_q, zop_d;
  logic             done_q;

  logic zero;
  logic x_ld, y_ld;
  logic x_sub, y_sub;
  logic done_rise;

  assign zero   = (x_q == '0) | (y_q == '0);
  assign x_eq_y = (x_q == y_q) | zero;
  assign x_gt_y = (x_q > y_q) & ~zero;

  // The x_eq_y guard keeps the controller's final compare cycle from zeroing Y.
  assign x_ld  = ~xhold & ~xload;
  assign y_ld  = ~yhold & ~yload;
  assign x_sub = xhold & xload & ~yload & ~x_eq_y;
  assign y_sub = yhold & yload & ~xload & ~x_eq_y;

  assign done_rise = done & ~done_q;

  always_comb begin
    x_d = x_q;
    if (x_ld) begin
      x_d = din;
    end else if (x_sub) begin
      x_d = x_q - y_q;
    end
  end

  always_comb begin
    y_d = y_q;
    if (y_ld) begin
      y_d = din;
    end else if (y_sub) begin
      y_d = y_q - x_q;
    end
  end

  // Capture outranks the clear when a new load coincides with done rising.
  always_comb begin
    gcd_d   = gcd_q;
    valid_d = valid_q;
    zop_d   = zop_q;
    if (done_rise) begin
      gcd_d   = x_q | y_q;
      valid_d = 1'b1;
      zop_d   = zero;
    end else if (!xhold) begin
      valid_d = 1'b0;
      zop_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q     <= '0;
      y_q     <= '0;
      gcd_q   <= '0;
      valid_q <= 1'b0;
      zop_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      gcd_q   <= gcd_d;
      valid_q <= valid_d;
      zop_q   <= zop_d;
      done_q  <= done;
    end
  end

  assign gcd_out      = gcd_q;
  assign result_valid = valid_q;
  assign zero_op      = zop_q;

`ifdef GCD_ITER_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating; frozen while a result is being presented.
  always_comb begin
    cnt_d = cnt_q;
    if (x_ld) begin
      cnt_d = '0;
    end else if (!valid_q && (x_sub || y_sub) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign iter_count = cnt_q;
`endif

endmodule

// File: tb/tb_gcd_datapath.sv
// Self-checking bench for gcd_datapath: table vectors, random operands, hand-written corner sequences.
module tb_gcd_datapath;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             xload, yload, xhold, yhold, done;
  logic             x_eq_y, x_gt_y;
  logic [WIDTH-1:0] gcd_out;
  logic             result_valid, zero_op;
`ifdef GCD_ITER_COUNT_EN
  logic [CNT_W-1:0] iter_count;
`endif

  int tests = 0;
  int fails = 0;

  gcd_datapath #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .xload        (xload),
    .yload        (yload),
    .xhold        (xhold),
    .yhold        (yhold),
    .done         (done),
    .x_eq_y       (x_eq_y),
    .x_gt_y       (x_gt_y),
    .gcd_out      (gcd_out),
    .result_valid (result_valid),
    .zero_op      (zero_op)
`ifdef GCD_ITER_COUNT_EN
    ,
    .iter_count   (iter_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int g;
    int z;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_strb(input logic xh, input logic xl, input logic yh, input logic yl, input logic dn);
    xhold = xh;
    xload = xl;
    yhold = yh;
    yload = yl;
    done  = dn;
  endtask

  function automatic int gcd_ref(input int a, input int b);
    int p, q, t;
    p = a;
    q = b;
    if (p == 0) return q;
    if (q == 0) return p;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Subtractive steps = sum of Euclid quotients minus one, saturated to the counter width.
  function automatic int iter_ref(input int a, input int b);
    int p, q, t, s, lim;
    if (a == 0 || b == 0) return 0;
    p = a;
    q = b;
    s = 0;
    while (q != 0) begin
      s = s + p / q;
      t = p % q;
      p = q;
      q = t;
    end
    s = s - 1;
    lim = (1 << CNT_W) - 1;
    return (s > lim) ? lim : s;
  endfunction

  task automatic load_xy(input int a, input int b);
    @(negedge clk);
    din = WIDTH'(a);
    set_strb(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    din = WIDTH'(b);
    set_strb(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Acts as the sequencing controller from known register contents; stops after the capture edge.
  task automatic run_loop(input int a, input int b);
    int mx, my;
    bit finished;
    mx = a;
    my = b;
    finished = 0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      check("status_eq", int'(x_eq_y), int'((mx == my) || mx == 0 || my == 0));
      check("status_gt", int'(x_gt_y), int'((mx > my) && mx != 0 && my != 0));
      if (mx == my || mx == 0 || my == 0) begin
        check("valid_before_done", int'(result_valid), 0);
        set_strb(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        finished = 1;
      end else if (mx > my) begin
        set_strb(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        mx = mx - my;
      end else begin
        set_strb(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        my = my - mx;
      end
    end
    if (!finished) check("loop_timeout", 1, 0);
    @(negedge clk);
    set_strb(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic run_case(input int a, input int b, input int exp_g, input int exp_z);
    load_xy(a, b);
    run_loop(a, b);
    check("gcd_out", int'(gcd_out), exp_g);
    check("result_valid", int'(result_valid), 1);
    check("zero_op", int'(zero_op), exp_z);
`ifdef GCD_ITER_COUNT_EN
    check("iter_count", int'(iter_count), iter_ref(a, b));
`endif
  endtask

  initial begin
    int ra, rb;
    tbl[0] = '{a: 48,  b: 18,  g: 6,   z: 0};
    tbl[1] = '{a: 7,   b: 7,   g: 7,   z: 0};
    tbl[2] = '{a: 0,   b: 9,   g: 9,   z: 1};
    tbl[3] = '{a: 9,   b: 0,   g: 9,   z: 1};
    tbl[4] = '{a: 13,  b: 1,   g: 1,   z: 0};
    tbl[5] = '{a: 0,   b: 0,   g: 0,   z: 1};
    tbl[6] = '{a: 255, b: 255, g: 255, z: 0};

    rst = 1'b0;
    din = '0;
    set_strb(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    check("rst_eq", int'(x_eq_y), 1);
    check("rst_gt", int'(x_gt_y), 0);
    check("rst_gcd", int'(gcd_out), 0);
    check("rst_valid", int'(result_valid), 0);
    check("rst_zop", int'(zero_op), 0);
`ifdef GCD_ITER_COUNT_EN
    check("rst_iter", int'(iter_count), 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_case(tbl[i].a, tbl[i].b, tbl[i].g, tbl[i].z);
    end

    // gcd_out holds 255 across a fresh load while result_valid drops
    @(negedge clk);
    din = 8'd4;
    set_strb(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("newload_valid", int'(result_valid), 0);
    check("newload_zop", int'(zero_op), 0);
    check("newload_gcd", int'(gcd_out), 255);
    check("newload_eq", int'(x_eq_y), 0);

    // Illegal hold/load combinations must leave X=4, Y=255 untouched
    din = 8'd255;
    set_strb(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("illegal_x_eq", int'(x_eq_y), 0);
    din = 8'd4;
    set_strb(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("illegal_y_eq", int'(x_eq_y), 0);
    set_strb(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("idle_eq", int'(x_eq_y), 0);
    check("idle_gt", int'(x_gt_y), 0);
    run_loop(4, 255);
    check("resume_gcd", int'(gcd_out), 1);
    check("resume_valid", int'(result_valid), 1);

    // Load and done rising together: capture of the old X|Y wins
    load_xy(12, 12);
    @(negedge clk);
    din = 8'd5;
    set_strb(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    set_strb(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("coll_valid", int'(result_valid), 1);
    check("coll_gcd", int'(gcd_out), 12);
    check("coll_zop", int'(zero_op), 0);
    check("coll_xload_gt", int'(x_gt_y), 0);
    check("coll_xload_eq", int'(x_eq_y), 0);

    for (int i = 0; i < 30; i++) begin
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      run_case(ra, rb, gcd_ref(ra, rb), int'(ra == 0 || rb == 0));
    end

    // Asynchronous reset mid-loop: X=30,Y=18 -> one X step -> X=12,Y=18
    load_xy(30, 18);
    @(negedge clk);
    set_strb(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    set_strb(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("pre_rst_eq", int'(x_eq_y), 0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_eq", int'(x_eq_y), 1);
    check("arst_gt", int'(x_gt_y), 0);
    check("arst_gcd", int'(gcd_out), 0);
    check("arst_valid", int'(result_valid), 0);
    check("arst_zop", int'(zero_op), 0);
    @(negedge clk);
    set_strb(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    run_case(30, 18, 6, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
